// File: rtl/uart_rx_controller.sv
// 16x-oversampling UART receiver: 8 data bits, even parity, 1 stop bit, with an output buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_rx_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic [2:0] baud_select,
    input  logic       RxD,
    input  logic       Rx_READY,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_OVERRUN,
    output logic       Rx_sample_ENABLE
);
    // state  | meaning
    // IDLE   | waiting for a low line on a sample tick
    // START  | validating the start bit (false start returns to IDLE)
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the even-parity bit
    // STOP   | checking the stop bit; frame pushed at tick 9
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic        r_rxd_meta, r_rxd_sync;
    logic [2:0]  r_baud;
    logic [13:0] r_div_cnt;
    logic        r_tick;
    logic [2:0]  r_state;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_s7, r_s8, r_par;
    logic        r_valid, r_overrun;

    logic [2:0]  w_baud;
    logic [13:0] w_div_reload;
    logic [3:0]  w_cnt_next;
    logic        w_maj, w_push, w_pop, w_full, w_push_ok;
    logic [9:0]  w_frame, w_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= RxD;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // While idle the live code is used so a new rate applies to the very next reload.
    assign w_baud = (r_state == S_IDLE) ? baud_select : r_baud;

    always_comb begin
        w_div_reload = 14'd26;
        case (w_baud)
            3'd0: w_div_reload = 14'd10416;
            3'd1: w_div_reload = 14'd2603;
            3'd2: w_div_reload = 14'd650;
            3'd3: w_div_reload = 14'd325;
            3'd4: w_div_reload = 14'd162;
            3'd5: w_div_reload = 14'd80;
            3'd6: w_div_reload = 14'd53;
            default: w_div_reload = 14'd26;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= 14'd0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == 14'd0) begin
            r_div_cnt <= w_div_reload;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt - 14'd1;
            r_tick    <= 1'b0;
        end
    end

    assign w_cnt_next = r_tick_cnt + 4'd1;
    assign w_maj      = (r_s7 & r_s8) | (r_s7 & r_rxd_sync) | (r_s8 & r_rxd_sync);
    assign w_push     = Rx_EN && r_tick && (r_state == S_STOP) && (w_cnt_next == 4'd9);
    assign w_frame    = {r_shift, (^r_shift) ^ r_par, ~w_maj};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_s7       <= 1'b0;
            r_s8       <= 1'b0;
            r_par      <= 1'b0;
            r_baud     <= 3'd0;
        end else begin
            if (r_state == S_IDLE)
                r_baud <= baud_select;
            if (!Rx_EN) begin
                r_state <= S_IDLE;
            end else if (r_tick) begin
                r_tick_cnt <= w_cnt_next;
                if (w_cnt_next == 4'd7) r_s7 <= r_rxd_sync;
                if (w_cnt_next == 4'd8) r_s8 <= r_rxd_sync;
                case (r_state)
                    S_IDLE: begin
                        if (!r_rxd_sync) begin
                            r_state    <= S_START;
                            r_tick_cnt <= 4'd0;
                        end
                    end
                    S_START: begin
                        if (w_cnt_next == 4'd9 && w_maj) begin
                            r_state <= S_IDLE;
                        end else if (w_cnt_next == 4'd15) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (w_cnt_next == 4'd9)
                            r_shift <= {w_maj, r_shift[7:1]};
                        if (w_cnt_next == 4'd15) begin
                            if (r_bit_idx == 3'd7) r_state <= S_PARITY;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        if (w_cnt_next == 4'd9)  r_par   <= w_maj;
                        if (w_cnt_next == 4'd15) r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (w_cnt_next == 4'd9) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_pop     = r_valid && Rx_READY;
    assign w_push_ok = w_push && (!w_full || w_pop);

`ifdef UART_RX_FIFO_EN
    logic [9:0] r_mem [0:3];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;

    assign w_full = (r_count == 3'd4);
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= 10'd0;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_frame;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b00, w_push_ok} - {2'b00, w_pop};
            // A freshly pushed entry becomes visible one clk after the push.
            r_valid <= (r_count - {2'b00, w_pop}) != 3'd0;
        end
    end
`else
    logic [9:0] r_hold;
    logic       r_full;

    assign w_full = r_full;
    assign w_head = r_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold  <= 10'd0;
            r_full  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_push_ok)
                r_hold <= w_frame;
            if (w_push_ok)
                r_full <= 1'b1;
            else if (w_pop)
                r_full <= 1'b0;
            r_valid <= r_full && !w_pop;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_overrun <= 1'b0;
        else if (w_push && w_full && !w_pop)
            r_overrun <= 1'b1;
        else if (w_pop)
            r_overrun <= 1'b0;
    end

    assign Rx_DATA          = w_head[9:2];
    assign Rx_PERROR        = w_head[1];
    assign Rx_FERROR        = w_head[0];
    assign Rx_VALID         = r_valid;
    assign Rx_OVERRUN       = r_overrun;
    assign Rx_sample_ENABLE = r_tick;

endmodule
